// File: rtl/fc_pkg.sv
// Shared definitions for the fc_* fully connected layer sequencers and datapaths.
// Holds the sequencer state encoding, the F6 input length and default element widths.
package fc_pkg;

  localparam int FC_IN_LEN    = 120;
  localparam int FC_BIT_WIDTH = 32;
  localparam int FC_OUT_WIDTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_CALC,
    ST_EMIT,
    ST_DONE
  } fc_state_t;

  // Packed width of a vector of len elements of bw bits each.
  function automatic int fc_vec_width(input int bw, input int len);
    return bw * len;
  endfunction

endpackage

// File: rtl/fc_120.sv
// Combinational 120-element signed dot product plus bias; zero latency, no flow control.
// Products and the running sum are formed at OUT_WIDTH bits, so the result wraps modulo 2**OUT_WIDTH.
module fc_120
  import fc_pkg::*;
#(
  parameter int BIT_WIDTH = FC_BIT_WIDTH,
  parameter int OUT_WIDTH = FC_OUT_WIDTH
) (
  input  logic [BIT_WIDTH*FC_IN_LEN-1:0] vec,
  input  logic [BIT_WIDTH*FC_IN_LEN-1:0] wts,
  input  logic [BIT_WIDTH-1:0]           bias,
  output logic signed [OUT_WIDTH-1:0]    result
);

  logic signed [OUT_WIDTH-1:0] acc;

  always_comb begin
    acc = OUT_WIDTH'($signed(bias));
    for (int i = 0; i < FC_IN_LEN; i++) begin
      acc = acc + OUT_WIDTH'($signed(vec[BIT_WIDTH*i +: BIT_WIDTH]))
                * OUT_WIDTH'($signed(wts[BIT_WIDTH*i +: BIT_WIDTH]));
    end
    result = acc;
  end

endmodule

// File: rtl/fc_120_ctrl.sv
// F6 sequencer: latches one activation vector, then per neuron FETCH/WAIT/CALC/EMIT (4 cycles when out_ready is high),
// holding each result while out_ready is low. Defining FC120_CTRL_RELU_EN clamps negative results to zero.
module fc_120_ctrl
  import fc_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int OUT_WIDTH   = 64,
  parameter int NUM_NEURONS = 84,
  parameter int ADDR_WIDTH  = 7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [BIT_WIDTH*FC_IN_LEN-1:0]  in_vec,
  output logic                            busy,
  output logic                            w_rd_en,
  output logic [ADDR_WIDTH-1:0]           w_addr,
  input  logic [BIT_WIDTH*FC_IN_LEN-1:0]  w_rdata,
  input  logic [BIT_WIDTH-1:0]            b_rdata,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic [ADDR_WIDTH-1:0]           out_idx,
  output logic                            done
);

  localparam int VEC_W = fc_vec_width(BIT_WIDTH, FC_IN_LEN);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_NEURONS - 1);

  fc_state_t                   state;
  logic [ADDR_WIDTH-1:0]       cnt;
  logic [VEC_W-1:0]            vec_q;
  logic [VEC_W-1:0]            w_q;
  logic [BIT_WIDTH-1:0]        b_q;
  logic signed [OUT_WIDTH-1:0] dot;
  logic signed [OUT_WIDTH-1:0] dot_act;

  // The datapath only ever sees registered operands, so CALC has a full cycle for the adder tree.
  fc_120 #(
    .BIT_WIDTH(BIT_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_fc_120 (
    .vec   (vec_q),
    .wts   (w_q),
    .bias  (b_q),
    .result(dot)
  );

`ifdef FC120_CTRL_RELU_EN
  assign dot_act = dot[OUT_WIDTH-1] ? '0 : dot;
`else
  assign dot_act = dot;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      vec_q     <= '0;
      w_q       <= '0;
      b_q       <= '0;
      busy      <= 1'b0;
      w_rd_en   <= 1'b0;
      w_addr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      w_rd_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec_q   <= in_vec;
            cnt     <= '0;
            w_addr  <= '0;
            w_rd_en <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          w_q   <= w_rdata;
          b_q   <= b_rdata;
          state <= ST_CALC;
        end
        ST_CALC: begin
          out_data  <= dot_act;
          out_idx   <= cnt;
          out_valid <= 1'b1;
          state     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cnt == LAST_IDX) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              cnt     <= cnt + 1'b1;
              w_addr  <= cnt + 1'b1;
              w_rd_en <= 1'b1;
              state   <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_120_ctrl.sv
// Bench for fc_120_ctrl: synchronous weight-memory model, scoreboard of expected neuron results,
// latency, backpressure, start-while-busy, back-to-back passes and mid-pass reset scenarios.
module tb_fc_120_ctrl;

  localparam int BW = 32;
  localparam int OW = 64;
  localparam int N  = 12;
  localparam int AW = 7;
  localparam int VW = BW * 120;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [VW-1:0] in_vec;
  logic          busy;
  logic          w_rd_en;
  logic [AW-1:0] w_addr;
  logic [VW-1:0] w_rdata;
  logic [BW-1:0] b_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          done;

  int wmode  = 0;
  int rd_cnt = 0;
  int passed = 0;
  int total  = 0;

  typedef struct {
    int     idx;
    longint data;
  } exp_t;
  exp_t sb[$];

  fc_120_ctrl #(
    .BIT_WIDTH(BW),
    .OUT_WIDTH(OW),
    .NUM_NEURONS(N),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_vec   (in_vec),
    .busy     (busy),
    .w_rd_en  (w_rd_en),
    .w_addr   (w_addr),
    .w_rdata  (w_rdata),
    .b_rdata  (b_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic int elem(input int vm, input int i);
    case (vm)
      0:       return 1;
      1:       return i - 60;
      default: return 3 * i + 1;
    endcase
  endfunction

  function automatic int wt(input int wm, input int n, input int i);
    case (wm)
      0:       return 2;
      1:       return n + 1;
      default: return ((i % 7) - 3) * (n + 1);
    endcase
  endfunction

  function automatic int bias_of(input int wm, input int n);
    case (wm)
      0:       return 5;
      1:       return -7;
      default: return n * 100 - 50;
    endcase
  endfunction

  function automatic longint expect_val(input int vm, input int wm, input int n);
    longint acc;
    acc = longint'(bias_of(wm, n));
    for (int i = 0; i < 120; i++) acc += longint'(elem(vm, i)) * longint'(wt(wm, n, i));
`ifdef FC120_CTRL_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  // Synchronous weight/bias memory: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (w_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      for (int i = 0; i < 120; i++) w_rdata[BW*i +: BW] <= wt(wmode, int'(w_addr), i);
      b_rdata <= bias_of(wmode, int'(w_addr));
    end
  end

  task automatic load_vec(input int vm);
    for (int i = 0; i < 120; i++) in_vec[BW*i +: BW] = elem(vm, i);
  endtask

  task automatic push_pass(input int vm, input int wm);
    exp_t e;
    for (int n = 0; n < N; n++) begin
      e.idx  = n;
      e.data = expect_val(vm, wm, n);
      sb.push_back(e);
    end
  endtask

  // One full pass from IDLE; optional 5-cycle stall on neuron stall_n, optional start poke during neuron poke_n.
  task automatic run_pass(input string name, input int vm, input int wm, input int stall_n, input int poke_n);
    int k, first_valid, done_k, stall_cnt, rd0, want_done;
    logic [OW-1:0] hold_d;
    logic [AW-1:0] hold_i;
    exp_t e;
    hold_d = '0;
    hold_i = '0;
    push_pass(vm, wm);
    load_vec(vm);
    wmode = wm;
    @(negedge clk);
    out_ready = 1'b1;
    start = 1'b1;
    rd0 = rd_cnt;
    @(negedge clk);
    start = 1'b0;
    k = 0; first_valid = -1; done_k = -1; stall_cnt = 0;
    while (done_k < 0 && k < 4 * N + 60) begin
      if (out_valid && first_valid < 0) first_valid = k;
      if (done) done_k = k;
      if (poke_n >= 0 && out_valid && int'(out_idx) == poke_n) begin
        start = 1'b1;
        load_vec(2);
      end else begin
        start = 1'b0;
      end
      if (stall_n >= 0 && out_valid && int'(out_idx) == stall_n && stall_cnt < 5) begin
        if (stall_cnt == 0) begin
          hold_d = out_data;
          hold_i = out_idx;
        end else begin
          total++;
          if (out_data !== hold_d || out_idx !== hold_i || w_rd_en !== 1'b0)
            $display("FAIL %s stall_hold: got data=%0d idx=%0d rd_en=%b, want data=%0d idx=%0d rd_en=0",
                     name, $signed(out_data), out_idx, w_rd_en, $signed(hold_d), hold_i);
          else passed++;
        end
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL %s result: got unexpected idx=%0d data=%0d, want none", name, out_idx, $signed(out_data));
        end else begin
          e = sb.pop_front();
          if (out_idx !== AW'(e.idx) || out_data !== e.data)
            $display("FAIL %s result: got idx=%0d data=%0d, want idx=%0d data=%0d",
                     name, out_idx, $signed(out_data), e.idx, e.data);
          else passed++;
        end
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    want_done = 4 * N + ((stall_n >= 0) ? 5 : 0);
    total++;
    if (first_valid !== 3) $display("FAIL %s first_valid: got cycle %0d, want 3", name, first_valid);
    else passed++;
    total++;
    if (done_k !== want_done) $display("FAIL %s done_cycle: got %0d, want %0d", name, done_k, want_done);
    else passed++;
    total++;
    if (rd_cnt - rd0 !== N) $display("FAIL %s rd_pulses: got %0d, want %0d", name, rd_cnt - rd0, N);
    else passed++;
    total++;
    if (sb.size() !== 0) begin
      $display("FAIL %s leftover: got %0d pending results, want 0", name, sb.size());
      sb.delete();
    end else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; in_vec = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, w_rd_en, out_valid, done} !== 4'b0000)
      $display("FAIL reset_flags: got busy/rd/valid/done=%b, want 0000", {busy, w_rd_en, out_valid, done});
    else passed++;
    total++;
    if (w_addr !== '0 || out_idx !== '0)
      $display("FAIL reset_addr: got w_addr=%0d out_idx=%0d, want 0/0", w_addr, out_idx);
    else passed++;
    total++;
    if (out_data !== '0) $display("FAIL reset_data: got %0d, want 0", out_data);
    else passed++;
  endtask

  task automatic test_basic;
    run_pass("basic", 0, 0, -1, -1);
  endtask

  task automatic test_signed;
    run_pass("signed", 1, 1, -1, -1);
  endtask

  task automatic test_backpressure;
    run_pass("backpressure", 2, 2, 1, -1);
  endtask

  task automatic test_start_busy;
    run_pass("start_busy", 0, 1, -1, 1);
  endtask

  task automatic test_back_to_back;
    int k, dones, low, maxlow;
    exp_t e;
    push_pass(0, 0);
    push_pass(1, 0);
    load_vec(0);
    wmode = 0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    load_vec(1);
    k = 0; dones = 0; low = 0; maxlow = 0;
    while (dones < 2 && k < 8 * N + 40) begin
      if (done) dones++;
      if (!busy) low++;
      else low = 0;
      if (low > maxlow) maxlow = low;
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL b2b result: got unexpected idx=%0d, want none", out_idx);
        end else begin
          e = sb.pop_front();
          if (out_idx !== AW'(e.idx) || out_data !== e.data)
            $display("FAIL b2b result: got idx=%0d data=%0d, want idx=%0d data=%0d",
                     out_idx, $signed(out_data), e.idx, e.data);
          else passed++;
        end
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    total++;
    if (dones !== 2) $display("FAIL b2b dones: got %0d, want 2", dones);
    else passed++;
    total++;
    if (maxlow !== 1) $display("FAIL b2b busy_gap: got %0d idle cycles, want 1", maxlow);
    else passed++;
    total++;
    if (sb.size() !== 0) begin
      $display("FAIL b2b leftover: got %0d pending results, want 0", sb.size());
      sb.delete();
    end else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int k, dones;
    bit hit;
    load_vec(0);
    wmode = 0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (out_valid && out_idx == 7'd10) hit = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!hit) $display("FAIL rst_mid reach: got no EMIT of neuron 10, want one");
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, w_rd_en, out_valid, done} !== 4'b0000)
      $display("FAIL rst_mid flags: got busy/rd/valid/done=%b, want 0000", {busy, w_rd_en, out_valid, done});
    else passed++;
    total++;
    if (out_data !== '0 || out_idx !== '0 || w_addr !== '0)
      $display("FAIL rst_mid regs: got data=%0d idx=%0d addr=%0d, want 0/0/0", out_data, out_idx, w_addr);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy || out_valid) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL rst_mid idle: got %0d active cycles after reset, want 0", dones);
    else passed++;
    run_pass("rst_restart", 1, 1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
